// File: rtl/power_pipe.sv
// -----------------------------------------------------------------------------
// power_pipe
//
// Fixed-depth pipeline computing x^n modulo 2^OUT_WIDTH for an unsigned
// operand x and a per-sample unsigned exponent n (saturated to MAX_EXP).
// The pipe has exactly MAX_EXP register stages. Stage 1 loads the operand and
// seeds the accumulator. Every later stage k multiplies once more when n >= k.
// All stages advance together whenever the output slot is empty or is being
// consumed, so bubbles are carried along rather than squeezed out.
//
// Optional feature macro: POWER_PIPE_OVF_FLAG_EN
//   defined     : full-precision products are formed, and a sticky per-stage
//                 overflow bit records any lost high-order bit; o_ovf
//                 reports it alongside the sample.
//   not defined : overflow logic is absent and o_ovf is tied to 0.
//
// Parameters
//   DATA_WIDTH  operand width (default 32)
//   OUT_WIDTH   result width, must be >= DATA_WIDTH (default 64)
//   MAX_EXP     largest exponent and pipeline depth, must be >= 1 (default 4)
//   EXP_WIDTH   derived exponent width, $clog2(MAX_EXP+1)
//
// Ports
//   clk      in   rising-edge clock
//   reset_n  in   asynchronous active-low reset (clears stage valid bits)
//   i_valid  in   upstream sample valid
//   o_ready  out  a sample can be accepted this cycle (combinational from i_ready)
//   i_data   in   operand x
//   i_exp    in   exponent n
//   o_valid  out  result valid
//   i_ready  in   downstream takes the result this cycle
//   o_data   out  x^n mod 2^OUT_WIDTH (0 when o_valid is low)
//   o_ovf    out  overflow flag for the sample on o_data
// -----------------------------------------------------------------------------
module power_pipe #(
    parameter  int DATA_WIDTH = 32,
    parameter  int OUT_WIDTH  = 64,
    parameter  int MAX_EXP    = 4,
    localparam int EXP_WIDTH  = $clog2(MAX_EXP + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [EXP_WIDTH-1:0]  i_exp,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_data,
    output logic                  o_ovf
);

    localparam int LAST = MAX_EXP - 1;

    // Stage s (0-based index) holds the state of pipeline stage s+1.
    logic                  vld_q [MAX_EXP];
    logic                  vld_d [MAX_EXP];
    logic [DATA_WIDTH-1:0] x_q   [MAX_EXP];
    logic [DATA_WIDTH-1:0] x_d   [MAX_EXP];
    logic [EXP_WIDTH-1:0]  n_q   [MAX_EXP];
    logic [EXP_WIDTH-1:0]  n_d   [MAX_EXP];
    logic [OUT_WIDTH-1:0]  acc_q [MAX_EXP];
    logic [OUT_WIDTH-1:0]  acc_d [MAX_EXP];
    logic                  advance;
    logic [EXP_WIDTH-1:0]  n_in;

    // Clamp an incoming exponent to the number of stages available.
    function automatic logic [EXP_WIDTH-1:0] sat_exp(input logic [EXP_WIDTH-1:0] e);
        if (e > EXP_WIDTH'(MAX_EXP)) begin
            return EXP_WIDTH'(MAX_EXP);
        end
        return e;
    endfunction

`ifdef POWER_PIPE_OVF_FLAG_EN
    localparam int PROD_W = OUT_WIDTH + DATA_WIDTH;

    logic              ovf_q [MAX_EXP];
    logic              ovf_d [MAX_EXP];
    logic [PROD_W-1:0] prod;

    // Full-precision product; bits above OUT_WIDTH-1 mark an overflow.
    function automatic logic [PROD_W-1:0] mul_full(input logic [OUT_WIDTH-1:0]  a,
                                                   input logic [DATA_WIDTH-1:0] b);
        return PROD_W'(a) * PROD_W'(b);
    endfunction
`else
    // Product truncated to the result width (wraps modulo 2^OUT_WIDTH).
    function automatic logic [OUT_WIDTH-1:0] mul_trunc(input logic [OUT_WIDTH-1:0]  a,
                                                       input logic [DATA_WIDTH-1:0] b);
        return a * OUT_WIDTH'(b);
    endfunction
`endif

    // Nothing moves while the last stage holds a result downstream refuses.
    assign advance = !vld_q[LAST] || i_ready;
    assign n_in    = sat_exp(i_exp);

    always_comb begin
        for (int s = 0; s < MAX_EXP; s++) begin
            vld_d[s] = vld_q[s];
            x_d[s]   = x_q[s];
            n_d[s]   = n_q[s];
            acc_d[s] = acc_q[s];
        end
`ifdef POWER_PIPE_OVF_FLAG_EN
        prod = '0;
        for (int s = 0; s < MAX_EXP; s++) begin
            ovf_d[s] = ovf_q[s];
        end
`endif
        if (advance) begin
            // ---- stage 1: load operand, seed accumulator ----
            vld_d[0] = i_valid;
            x_d[0]   = i_data;
            n_d[0]   = n_in;
            acc_d[0] = (n_in == '0) ? OUT_WIDTH'(1) : OUT_WIDTH'(i_data);
`ifdef POWER_PIPE_OVF_FLAG_EN
            ovf_d[0] = 1'b0;
`endif
            // ---- stages 2..MAX_EXP: one conditional multiply each ----
            for (int s = 1; s < MAX_EXP; s++) begin
                vld_d[s] = vld_q[s-1];
                x_d[s]   = x_q[s-1];
                n_d[s]   = n_q[s-1];
                acc_d[s] = acc_q[s-1];
`ifdef POWER_PIPE_OVF_FLAG_EN
                ovf_d[s] = ovf_q[s-1];
                if (n_q[s-1] >= EXP_WIDTH'(s + 1)) begin
                    prod     = mul_full(acc_q[s-1], x_q[s-1]);
                    acc_d[s] = prod[OUT_WIDTH-1:0];
                    // Sticky: once a sample overflowed it stays flagged.
                    ovf_d[s] = ovf_q[s-1] || (prod[PROD_W-1:OUT_WIDTH] != '0);
                end
`else
                if (n_q[s-1] >= EXP_WIDTH'(s + 1)) begin
                    acc_d[s] = mul_trunc(acc_q[s-1], x_q[s-1]);
                end
`endif
            end
        end
    end

    // Only the valid bits need reset; data in an invalid stage is never observed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < MAX_EXP; s++) begin
                vld_q[s] <= 1'b0;
            end
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        x_q   <= x_d;
        n_q   <= n_d;
        acc_q <= acc_d;
`ifdef POWER_PIPE_OVF_FLAG_EN
        ovf_q <= ovf_d;
`endif
    end

    // Outputs are gated by the last valid bit so they read 0 in and after reset.
    assign o_ready = advance;
    assign o_valid = vld_q[LAST];
    assign o_data  = vld_q[LAST] ? acc_q[LAST] : '0;
`ifdef POWER_PIPE_OVF_FLAG_EN
    assign o_ovf   = vld_q[LAST] && ovf_q[LAST];
`else
    assign o_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_power_pipe.sv
// -----------------------------------------------------------------------------
// tb_power_pipe
//
// Directed bench for power_pipe with default parameters. A driver issues
// samples with hand-computed expected results pushed into a scoreboard queue
// at acceptance; an independent monitor pops and compares every delivered
// result, and also watches the stall behaviour.
// -----------------------------------------------------------------------------
module tb_power_pipe;

    localparam int DW = 32;
    localparam int OW = 64;
    localparam int ME = 4;
    localparam int EW = 3;

`ifdef POWER_PIPE_OVF_FLAG_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          i_valid;
    logic          o_ready;
    logic [DW-1:0] i_data;
    logic [EW-1:0] i_exp;
    logic          o_valid;
    logic          i_ready;
    logic [OW-1:0] o_data;
    logic          o_ovf;

    power_pipe #(
        .DATA_WIDTH (DW),
        .OUT_WIDTH  (OW),
        .MAX_EXP    (ME)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_exp   (i_exp),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_ovf   (o_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        ovf;
        int          acc_cyc;
        bit          chk_lat;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // Monitor: samples at the falling edge, away from the active edge.
    initial begin
        logic        stall_prev;
        logic [63:0] stall_data;
        int          out_idx;
        exp_t        e;
        stall_prev = 1'b0;
        stall_data = '0;
        out_idx    = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev) begin
                    check("stall_hold_data", o_data, stall_data);
                    check("stall_hold_valid", 64'(o_valid), 64'd1);
                end
                stall_prev = 1'b0;
                if (o_valid && !i_ready) begin
                    check("stall_o_ready", 64'(o_ready), 64'd0);
                    stall_prev = 1'b1;
                    stall_data = o_data;
                end
                if (o_valid && i_ready) begin
                    if (sb.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_output: got 0x%0h, want no output", o_data);
                    end else begin
                        e = sb.pop_front();
                        check($sformatf("data[%0d]", out_idx), o_data, e.d);
                        check($sformatf("ovf[%0d]", out_idx), 64'(o_ovf), 64'(e.ovf));
                        if (e.chk_lat) begin
                            check($sformatf("latency[%0d]", out_idx), 64'(cyc - e.acc_cyc), 64'd4);
                        end
                        out_idx++;
                    end
                end
            end
        end
    end

    // Drive a sample; when o_ready is seen at the falling edge it will be
    // accepted on the next rising edge, so the expectation is queued then.
    task automatic send(input logic [DW-1:0] x, input logic [EW-1:0] n,
                        input logic [63:0] d, input logic ovf, input bit lat, input bit sync);
        int   w;
        exp_t e;
        if (sync) begin
            @(posedge clk);
            #1;
        end
        i_valid = 1'b1;
        i_data  = x;
        i_exp   = n;
        w = 0;
        forever begin
            @(negedge clk);
            if (o_ready) break;
            w++;
            if (w > 30) begin
                n_chk++;
                n_fail++;
                $display("FAIL accept_timeout: got o_ready=0 for %0d cycles, want 1", w);
                return;
            end
        end
        e.d       = d;
        e.ovf     = ovf;
        e.acc_cyc = cyc;
        e.chk_lat = lat;
        sb.push_back(e);
    endtask

    // One empty cycle with junk on the data lines that must be ignored.
    task automatic idle();
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_data  = 32'hDEADBEEF;
        i_exp   = 3'd7;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d results pending, want 0", sb.size());
            sb.delete();
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic stall_ctrl();
        int w;
        w = 0;
        while (!o_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!o_valid) begin
            n_chk++;
            n_fail++;
            $display("FAIL stall_wait: got o_valid=0, want 1");
        end
        @(posedge clk);
        #1;
        i_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        i_ready = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_data  = '0;
        i_exp   = '0;

        #2;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_o_data",  o_data,       64'd0);
        check("rst_o_ovf",   64'(o_ovf),   64'd0);
        check("rst_o_ready", 64'(o_ready), 64'd1);

        // Release reset and present a sample for the very next rising edge.
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Back-to-back cubes.
        send(32'd2,  3'd3, 64'h8,   1'b0, 1'b1, 1'b0);
        send(32'd3,  3'd3, 64'h1B,  1'b0, 1'b1, 1'b1);
        send(32'd5,  3'd3, 64'h7D,  1'b0, 1'b1, 1'b1);
        send(32'd7,  3'd3, 64'h157, 1'b0, 1'b1, 1'b1);
        send(32'hA,  3'd3, 64'h3E8, 1'b0, 1'b1, 1'b1);
        idle();
        drain();

        // Exponent edges, including saturation and 0^0.
        send(32'd5, 3'd0, 64'h1,  1'b0, 1'b1, 1'b1);
        send(32'd2, 3'd1, 64'h2,  1'b0, 1'b1, 1'b1);
        send(32'd2, 3'd7, 64'h10, 1'b0, 1'b1, 1'b1);
        send(32'd0, 3'd0, 64'h1,  1'b0, 1'b1, 1'b1);
        idle();
        drain();

        // Overflow behaviour.
        send(32'hFFFFFFFF, 3'd3, 64'h0000_0002_FFFF_FFFF, OVF_EXP, 1'b1, 1'b1);
        send(32'hFFFFFFFF, 3'd2, 64'hFFFF_FFFE_0000_0001, 1'b0,    1'b1, 1'b1);
        idle();
        drain();

        // Downstream stall for 3 cycles while results are waiting.
        fork
            begin
                send(32'd1, 3'd2, 64'd1,  1'b0, 1'b0, 1'b1);
                send(32'd2, 3'd2, 64'd4,  1'b0, 1'b0, 1'b1);
                send(32'd3, 3'd2, 64'd9,  1'b0, 1'b0, 1'b1);
                send(32'd4, 3'd2, 64'd16, 1'b0, 1'b0, 1'b1);
                send(32'd5, 3'd2, 64'd25, 1'b0, 1'b0, 1'b1);
                idle();
            end
            stall_ctrl();
        join
        drain();

        // Bubbles between samples.
        send(32'd2, 3'd4, 64'h10,  1'b0, 1'b1, 1'b1);
        idle();
        send(32'd3, 3'd4, 64'h51,  1'b0, 1'b1, 1'b1);
        idle();
        send(32'd5, 3'd4, 64'h271, 1'b0, 1'b1, 1'b1);
        idle();
        drain();

        // Reset while three samples are in flight; none may emerge.
        send(32'd7, 3'd1, 64'd7, 1'b0, 1'b0, 1'b1);
        send(32'd8, 3'd1, 64'd8, 1'b0, 1'b0, 1'b1);
        send(32'd9, 3'd1, 64'd9, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        i_valid = 1'b0;
        sb.delete();
        #1;
        check("midrst_o_valid", 64'(o_valid), 64'd0);
        check("midrst_o_data",  o_data,       64'd0);
        check("midrst_o_ready", 64'(o_ready), 64'd1);
        repeat (2) @(posedge clk);
        #3;
        reset_n = 1'b1;
        send(32'd3, 3'd2, 64'h9, 1'b0, 1'b1, 1'b1);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
